// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 8-bit CPU control path.
//   state_t : control FSM states (HALT only reachable with CU_HALT_INST_EN)
//   OP_*    : upper-nibble opcodes of the instruction byte; IR[7]=1 is ALU class
//   PC_W    : program counter / memory address width
//   REG_AW  : register-file address width
package cpu_pkg;

  localparam int PC_W   = 10;
  localparam int REG_AW = 2;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JMP   = 4'b0010;
  localparam logic [3:0] OP_HALT  = 4'b0011;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    ADDR  = 3'd2,
    MEM   = 3'd3,
    HALT  = 3'd4
  } state_t;

  // Opcodes that carry a second (address) byte.
  function automatic logic is_two_byte(input logic [7:0] ir);
    return (ir[7:4] == OP_LOAD) || (ir[7:4] == OP_STORE) || (ir[7:4] == OP_JMP);
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: memory bus plus datapath control signals.
//   inst  : memory read data for the current amem (driven by memory side)
//   amem  : memory address
//   aa/ab : register-file read addresses (ab also sources store data)
//   ad    : register-file write address
//   wr    : register write enable
//   md    : write-back select (0 = ALU, 1 = memory data)
//   mw    : memory write strobe
// master = control unit, slave = memory/datapath.
interface cpu_control_unit_if;
  import cpu_pkg::*;

  logic [7:0]        inst;
  logic [PC_W-1:0]   amem;
  logic [REG_AW-1:0] aa;
  logic [REG_AW-1:0] ab;
  logic [REG_AW-1:0] ad;
  logic              wr;
  logic              md;
  logic              mw;

  modport master (input inst, output amem, aa, ab, ad, wr, md, mw);
  modport slave  (output inst, input amem, aa, ab, ad, wr, md, mw);

endinterface

// File: rtl/cu_decoder.sv
// cu_decoder: purely combinational output decode of the control unit.
//   state_i : current FSM state
//   ir_i    : instruction register
//   ar_i    : address register (low byte of effective address)
//   pc_i    : program counter
//   amem_o, aa_o, ab_o, ad_o, wr_o, md_o, mw_o : bus / datapath controls
// With IR=0 (reset) every register address decodes to 0 and all strobes are 0.
module cu_decoder
  import cpu_pkg::*;
(
  input  state_t            state_i,
  input  logic [7:0]        ir_i,
  input  logic [7:0]        ar_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [PC_W-1:0]   amem_o,
  output logic [REG_AW-1:0] aa_o,
  output logic [REG_AW-1:0] ab_o,
  output logic [REG_AW-1:0] ad_o,
  output logic              wr_o,
  output logic              md_o,
  output logic              mw_o
);

  logic [REG_AW-1:0] r_fld;
  logic [REG_AW-1:0] s_fld;

  assign r_fld = ir_i[3:2];
  assign s_fld = ir_i[1:0];

  always_comb begin
    amem_o = pc_i;
    aa_o   = r_fld;
    ab_o   = s_fld;
    ad_o   = r_fld;
    wr_o   = 1'b0;
    md_o   = 1'b0;
    mw_o   = 1'b0;

    unique case (state_i)
      EXEC: begin
        // Only the ALU class writes back; the remaining 0xxx opcodes here are NOPs.
        if (ir_i[7]) wr_o = 1'b1;
      end
      MEM: begin
        amem_o = {s_fld, ar_i};
        if (ir_i[7:4] == OP_LOAD) begin
          wr_o = 1'b1;
          md_o = 1'b1;
        end else if (ir_i[7:4] == OP_STORE) begin
          // Store data comes out of read port B, so point it at r.
          aa_o = r_fld;
          ab_o = r_fld;
          mw_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/execute sequencer for the 8-bit CPU.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cpu_control_unit_if.master (inst in; amem/aa/ab/ad/wr/md/mw out)
// Parameter RESET_PC sets the PC value loaded on reset.
// Optional macro CU_HALT_INST_EN: opcode 0011 halts until reset; otherwise NOP.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 10'h000
)(
  input  logic                 clk,
  input  logic                 rst_n,
  cpu_control_unit_if.master   bus
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      ar_q, ar_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      ar_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ar_q    <= ar_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ar_d    = ar_q;

    unique case (state_q)
      FETCH: begin
        ir_d = bus.inst;
        pc_d = pc_q + PC_W'(1);   // wraps 1023 -> 0 naturally
        if (bus.inst[7])
          state_d = EXEC;
        else if (is_two_byte(bus.inst))
          state_d = ADDR;
`ifdef CU_HALT_INST_EN
        else if (bus.inst[7:4] == OP_HALT)
          state_d = HALT;
`endif
        else
          state_d = EXEC;
      end
      EXEC: state_d = FETCH;
      ADDR: begin
        ar_d = bus.inst;
        if (ir_q[7:4] == OP_JMP) begin
          pc_d    = {ir_q[1:0], bus.inst};
          state_d = FETCH;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = MEM;
        end
      end
      MEM:  state_d = FETCH;
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  cu_decoder u_dec (
    .state_i (state_q),
    .ir_i    (ir_q),
    .ar_i    (ar_q),
    .pc_i    (pc_q),
    .amem_o  (bus.amem),
    .aa_o    (bus.aa),
    .ab_o    (bus.ab),
    .ad_o    (bus.ad),
    .wr_o    (bus.wr),
    .md_o    (bus.md),
    .mw_o    (bus.mw)
  );

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed checks of cpu_control_unit against a small
// program image. Inputs change and outputs are sampled on the falling edge.
module tb_cpu_control_unit;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [7:0] mem [0:1023];

  cpu_control_unit_if bus ();

  assign bus.inst = mem[bus.amem];

  cpu_control_unit #(.RESET_PC(10'h000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check that wr and mw are never both asserted.
  task automatic step();
    @(negedge clk);
    chk("wr_mw_excl", {15'd0, bus.wr & bus.mw}, 16'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h40;  // NOP filler
    mem[0]      = 8'h84;
    mem[1]      = 8'h87;
    mem[2]      = 8'h97;
    mem[3]      = 8'h0B; mem[4] = 8'h25;
    mem[5]      = 8'h1A; mem[6] = 8'hFF;
    mem[7]      = 8'h23; mem[8] = 8'h10;
    mem[10'h310] = 8'h23; mem[10'h311] = 8'hFF;
    mem[10'h3FF] = 8'h84;

    // 1. reset and first ALU instruction
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_amem", 16'(bus.amem), 16'h000);
    chk("rst_regs", {10'd0, bus.aa, bus.ab, bus.ad}, 16'd0);
    chk("rst_strobes", {13'd0, bus.wr, bus.md, bus.mw}, 16'd0);
    rst_n = 1'b1;
    $display("[TB] reset released");
    chk("fetch0_amem", 16'(bus.amem), 16'h000);
    step();
    chk("exec84_aa", 16'(bus.aa), 16'd1);
    chk("exec84_ab", 16'(bus.ab), 16'd0);
    chk("exec84_ad", 16'(bus.ad), 16'd1);
    chk("exec84_wr_md_mw", {13'd0, bus.wr, bus.md, bus.mw}, 16'b100);
    step();
    chk("fetch1_amem", 16'(bus.amem), 16'h001);
    chk("fetch1_wr", 16'(bus.wr), 16'd0);

    // 2. two ALU instructions
    step();
    chk("exec87_regs", {10'd0, bus.aa, bus.ab, bus.ad}, {10'd0, 2'd1, 2'd3, 2'd1});
    chk("exec87_wr_mw", {14'd0, bus.wr, bus.mw}, 16'b10);
    step();
    chk("fetch2_amem", 16'(bus.amem), 16'h002);
    step();
    chk("exec97_regs", {10'd0, bus.aa, bus.ab, bus.ad}, {10'd0, 2'd1, 2'd3, 2'd1});
    chk("exec97_wr_mw", {14'd0, bus.wr, bus.mw}, 16'b10);
    $display("[TB] ALU sequence done");

    // 3. LOAD r2, 0x325
    step();
    chk("load_fetch_amem", 16'(bus.amem), 16'h003);
    step();
    chk("load_addr_amem", 16'(bus.amem), 16'h004);
    chk("load_addr_wr", 16'(bus.wr), 16'd0);
    step();
    chk("load_mem_amem", 16'(bus.amem), 16'h325);
    chk("load_mem_wr_md_mw", {13'd0, bus.wr, bus.md, bus.mw}, 16'b110);
    chk("load_mem_ad", 16'(bus.ad), 16'd2);
    $display("[TB] LOAD done");

    // 4. STORE r2, 0x2FF
    step();
    chk("store_fetch_amem", 16'(bus.amem), 16'h005);
    step();
    chk("store_addr_amem", 16'(bus.amem), 16'h006);
    chk("store_addr_mw", 16'(bus.mw), 16'd0);
    step();
    chk("store_mem_amem", 16'(bus.amem), 16'h2FF);
    chk("store_mem_mw", 16'(bus.mw), 16'd1);
    chk("store_mem_ab", 16'(bus.ab), 16'd2);
    chk("store_mem_aa", 16'(bus.aa), 16'd2);
    chk("store_mem_wr", 16'(bus.wr), 16'd0);
    $display("[TB] STORE done");

    // 5. JMP 0x310, then JMP 0x3FF and PC wrap on ALU instruction
    step();
    chk("jmp_fetch_amem", 16'(bus.amem), 16'h007);
    step();
    chk("jmp_addr_amem", 16'(bus.amem), 16'h008);
    chk("jmp_addr_strobes", {13'd0, bus.wr, bus.md, bus.mw}, 16'd0);
    step();
    chk("jmp_target_amem", 16'(bus.amem), 16'h310);
    step();
    chk("jmp2_addr_amem", 16'(bus.amem), 16'h311);
    step();
    chk("wrap_fetch_amem", 16'(bus.amem), 16'h3FF);
    step();
    chk("wrap_exec_amem", 16'(bus.amem), 16'h000);
    chk("wrap_exec_wr", 16'(bus.wr), 16'd1);
    step();
    chk("wrap_fetch0_amem", 16'(bus.amem), 16'h000);
    $display("[TB] JMP and wrap done");

    // 6. rerun from 0 up to the STORE MEM cycle, then abort it with reset
    repeat (11) step();
    chk("abort_pre_amem", 16'(bus.amem), 16'h2FF);
    chk("abort_pre_mw", 16'(bus.mw), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mw_drop", 16'(bus.mw), 16'd0);
    chk("abort_amem", 16'(bus.amem), 16'h000);
    chk("abort_regs", {10'd0, bus.aa, bus.ab, bus.ad}, 16'd0);
    @(negedge clk);
    chk("abort_held_mw", 16'(bus.mw), 16'd0);
    rst_n = 1'b1;
    chk("abort_rel_amem", 16'(bus.amem), 16'h000);
    chk("abort_rel_mw", 16'(bus.mw), 16'd0);
    step();
    chk("abort_exec_mw", 16'(bus.mw), 16'd0);
    chk("abort_exec_wr", 16'(bus.wr), 16'd1);
    $display("[TB] reset abort done");

    // Opcode 0011 at address 0
    mem[0] = 8'h30;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("op3_fetch_amem", 16'(bus.amem), 16'h000);
`ifdef CU_HALT_INST_EN
    for (int k = 0; k < 4; k++) begin
      step();
      chk("halt_amem", 16'(bus.amem), 16'h001);
      chk("halt_strobes", {13'd0, bus.wr, bus.md, bus.mw}, 16'd0);
    end
    rst_n = 1'b0;
    #1;
    chk("halt_rst_amem", 16'(bus.amem), 16'h000);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] HALT done");
`else
    step();
    chk("op3_nop_amem", 16'(bus.amem), 16'h001);
    chk("op3_nop_strobes", {13'd0, bus.wr, bus.md, bus.mw}, 16'd0);
    step();
    chk("op3_next_fetch", 16'(bus.amem), 16'h001);
    step();
    chk("op3_next_exec_wr", 16'(bus.wr), 16'd1);
    $display("[TB] opcode 0011 NOP done");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
